// File: rtl/ad5302_pkg.sv
// Shared command-word layout and defaults for the AD5302 command path.
package ad5302_pkg;

  localparam logic [11:0] HDR_VAL_DEF = 12'hDAC;
  localparam logic [3:0]  CH_MAX_DEF  = 4'd1;

  localparam int HDR_MSB  = 31;
  localparam int HDR_LSB  = 20;
  localparam int CH_MSB   = 19;
  localparam int CH_LSB   = 16;
  localparam int DATA_MSB = 15;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } asm_state_t;

  // True when the header matches and the channel is within range.
  function automatic logic frame_ok(input logic [31:0] word,
                                    input logic [11:0] hdr_val,
                                    input logic [3:0]  ch_max);
    return (word[HDR_MSB:HDR_LSB] == hdr_val) && (word[CH_MSB:CH_LSB] <= ch_max);
  endfunction

  // Data field of a command word.
  function automatic logic [DATA_MSB:0] cmd_data(input logic [31:0] word);
    return word[DATA_MSB:0];
  endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Idle-gap counter: clears on demand, counts while enabled, and stops at
// LIMIT-1 where it raises a terminal-count flag. It never wraps.
module byte_gap_timer #(
  parameter int LIMIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(LIMIT) + 1;
  localparam logic [CW-1:0] TERM = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc = (r_cnt == TERM);
  assign o_tc = w_tc;

  // Count idle cycles; clear has priority, saturate at the terminal value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en && !w_tc)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Packs four UART bytes (MSB first) into a 32-bit command, checks the header
// and channel, and publishes accepted words with a one-cycle ready pulse.
// Partial frames are dropped after an inter-byte idle gap.
module uart_cmd_assembler
  import ad5302_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter bit          HDR_EN         = 1'b1,
  parameter logic [11:0] HDR_VAL        = HDR_VAL_DEF,
  parameter logic [3:0]  CH_MAX         = CH_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] uart_reg,
  output logic        uart_ready,
  output logic        frame_err,
  output logic [1:0]  byte_cnt
);

  asm_state_t  r_state;
  asm_state_t  w_next;
  logic [31:0] r_shift;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_reg;
  logic        r_ready;
  logic        r_err;

  logic        w_timer_clr;
  logic        w_timer_en;
  logic        w_tc;
  logic        w_done;
  logic        w_tmo;
  logic        w_ok;
  logic [31:0] w_word;
  logic [4:0]  w_lane;

  // The completing byte goes straight into the word, not via the shift register.
  assign w_word = {r_shift[31:8], rx_data};
  assign w_ok   = !HDR_EN || frame_ok(w_word, HDR_VAL, CH_MAX);
  assign w_lane = {2'd3 - r_byte_cnt, 3'b000};

  byte_gap_timer #(.LIMIT(TIMEOUT_CYCLES)) u_gap (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_timer_clr),
    .i_en  (w_timer_en),
    .o_tc  (w_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next state, timer control and frame-complete / timeout decode.
  always_comb begin
    w_next      = r_state;
    w_timer_clr = 1'b1;
    w_timer_en  = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid)
          w_next = S_COLLECT;
      end
      S_COLLECT: begin
        // A byte arriving on the terminal count still wins over the timeout.
        w_timer_clr = rx_valid;
        w_timer_en  = !rx_valid;
        if (rx_valid && (r_byte_cnt == 2'd3)) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end else if (!rx_valid && w_tc) begin
          w_next = S_IDLE;
          w_tmo  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Byte lanes, byte count, published word and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_reg      <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ready <= w_done && w_ok;
      r_err   <= (w_done && !w_ok) || w_tmo;
      if (w_done && w_ok)
        r_reg <= w_word;
      if (rx_valid) begin
        if (r_state == S_IDLE) begin
          r_shift    <= {rx_data, 24'h000000};
          r_byte_cnt <= 2'd1;
        end else if (r_byte_cnt == 2'd3) begin
          r_byte_cnt <= 2'd0;
        end else begin
          r_shift[w_lane +: 8] <= rx_data;
          r_byte_cnt           <= r_byte_cnt + 2'd1;
        end
      end else if (w_tmo) begin
        r_byte_cnt <= 2'd0;
      end
    end
  end

  assign uart_reg   = r_reg;
  assign uart_ready = r_ready;
  assign frame_err  = r_err;
  assign byte_cnt   = r_byte_cnt;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Bench for uart_cmd_assembler: two instances (header check on / off) share
// one byte stream; a frame-level model predicts every output each cycle.
module tb_uart_cmd_assembler;

  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic [31:0] reg_c, reg_p;
  logic        rdy_c, rdy_p, err_c, err_p;
  logic [1:0]  bc_c, bc_p;

  always #5 clk = ~clk;

  uart_cmd_assembler #(.TIMEOUT_CYCLES(T), .HDR_EN(1'b1)) u_chk (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .uart_reg(reg_c), .uart_ready(rdy_c), .frame_err(err_c), .byte_cnt(bc_c));

  uart_cmd_assembler #(.TIMEOUT_CYCLES(T), .HDR_EN(1'b0)) u_pass (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .uart_reg(reg_p), .uart_ready(rdy_p), .frame_err(err_p), .byte_cnt(bc_p));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 = pass-all instance, 1 = header-checking instance.
  logic [7:0]  mb   [2][4];
  int          mn   [2];
  int          mgap [2];
  logic [31:0] mreg [2];
  logic        mrdy [2];
  logic        merr [2];

  function automatic bit legal(input logic [31:0] w);
    return (w[31:20] == 12'hDAC) && (w[19:16] <= 4'd1);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          mn[k] = 0; mgap[k] = 0; mreg[k] = '0; mrdy[k] = 1'b0; merr[k] = 1'b0;
        end else begin
          mrdy[k] = 1'b0;
          merr[k] = 1'b0;
          if (rx_valid) begin
            mb[k][mn[k]] = rx_data;
            mn[k]++;
            mgap[k] = 0;
            if (mn[k] == 4) begin
              logic [31:0] w;
              w = {mb[k][0], mb[k][1], mb[k][2], mb[k][3]};
              if (k == 0 || legal(w)) begin
                mreg[k] = w;
                mrdy[k] = 1'b1;
              end else begin
                merr[k] = 1'b1;
              end
              mn[k] = 0;
            end
          end else if (mn[k] > 0) begin
            mgap[k]++;
            if (mgap[k] == T) begin
              merr[k] = 1'b1;
              mn[k]   = 0;
              mgap[k] = 0;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison and pulse counting.
  int cnt_rdy [2] = '{0, 0};
  int cnt_err [2] = '{0, 0};

  initial begin
    @(negedge clk);
    forever begin
      @(negedge clk);
      chk("chk_reg", reg_c, mreg[1]);
      chk("chk_rdy", {31'd0, rdy_c}, {31'd0, mrdy[1]});
      chk("chk_err", {31'd0, err_c}, {31'd0, merr[1]});
      chk("chk_bc",  {30'd0, bc_c}, 32'(mn[1]));
      chk("pass_reg", reg_p, mreg[0]);
      chk("pass_rdy", {31'd0, rdy_p}, {31'd0, mrdy[0]});
      chk("pass_err", {31'd0, err_p}, {31'd0, merr[0]});
      chk("pass_bc",  {30'd0, bc_p}, 32'(mn[0]));
      if (rdy_c) cnt_rdy[1]++;
      if (err_c) cnt_err[1]++;
      if (rdy_p) cnt_rdy[0]++;
      if (err_p) cnt_err[0]++;
    end
  end

  // Stimulus helpers; called on a falling edge, return on a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      strobe(w[8*i +: 8]);
      if (i != 0) idle(gap);
    end
  endtask

  int r0, e0, p0;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    chk("rst_reg", reg_c, 32'h0);
    chk("rst_bc", {30'd0, bc_c}, 32'h0);
    rst = 1'b0;
    idle(2);

    // Slow frame, gaps below the timeout.
    r0 = cnt_rdy[1]; e0 = cnt_err[1];
    frame(32'hDAC01234, 45);
    idle(2);
    chk("slow_reg", reg_c, 32'hDAC01234);
    chk("slow_model", mreg[1], 32'hDAC01234);
    chk("slow_rdy_n", 32'(cnt_rdy[1] - r0), 32'd1);
    chk("slow_err_n", 32'(cnt_err[1] - e0), 32'd0);

    // Back-to-back bytes.
    r0 = cnt_rdy[1];
    frame(32'hDAC11235, 0);
    idle(2);
    chk("b2b_reg", reg_c, 32'hDAC11235);
    chk("b2b_rdy_n", 32'(cnt_rdy[1] - r0), 32'd1);

    // Bad header: rejected when checked, passed otherwise.
    r0 = cnt_rdy[1]; e0 = cnt_err[1]; p0 = cnt_rdy[0];
    frame(32'hABC01234, 1);
    idle(2);
    chk("hdr_reg_kept", reg_c, 32'hDAC11235);
    chk("hdr_err_n", 32'(cnt_err[1] - e0), 32'd1);
    chk("hdr_rdy_n", 32'(cnt_rdy[1] - r0), 32'd0);
    chk("hdr_pass_reg", reg_p, 32'hABC01234);
    chk("hdr_pass_rdy_n", 32'(cnt_rdy[0] - p0), 32'd1);

    // Channel out of range.
    r0 = cnt_rdy[1]; e0 = cnt_err[1];
    frame(32'hDAC20001, 0);
    idle(2);
    chk("ch_err_n", 32'(cnt_err[1] - e0), 32'd1);
    chk("ch_rdy_n", 32'(cnt_rdy[1] - r0), 32'd0);

    // Timeout after two bytes, then a clean frame.
    r0 = cnt_rdy[1]; e0 = cnt_err[1];
    strobe(8'hDA); strobe(8'hC0);
    idle(T);
    chk("tmo_err_n", 32'(cnt_err[1] - e0), 32'd1);
    chk("tmo_bc", {30'd0, bc_c}, 32'h0);
    frame(32'hDAC000FF, 0);
    idle(2);
    chk("tmo_next_reg", reg_c, 32'hDAC000FF);
    chk("tmo_rdy_n", 32'(cnt_rdy[1] - r0), 32'd1);

    // Reset mid-frame.
    strobe(8'hDA); strobe(8'hC1);
    r0 = cnt_rdy[1]; e0 = cnt_err[1];
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_mid_reg", reg_c, 32'h0);
    frame(32'hDAC1AA55, 2);
    idle(2);
    chk("rst_mid_after", reg_c, 32'hDAC1AA55);
    chk("rst_mid_rdy_n", 32'(cnt_rdy[1] - r0), 32'd1);
    chk("rst_mid_err_n", 32'(cnt_err[1] - e0), 32'd0);

    // Each byte lands exactly on the terminal count.
    e0 = cnt_err[1];
    frame(32'hDAC00007, T - 1);
    idle(2);
    chk("tc_reg", reg_c, 32'hDAC00007);
    chk("tc_err_n", 32'(cnt_err[1] - e0), 32'd0);

    // Randomised traffic.
    for (int f = 0; f < 400; f++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(3) != 0)
        w[31:16] = {12'hDAC, 4'($urandom_range(2))};
      for (int i = 3; i >= 0; i--) begin
        int sel;
        strobe(w[8*i +: 8]);
        if (i != 0) begin
          sel = $urandom_range(9);
          if (sel == 0)      idle(T);
          else if (sel == 1) idle(T - 1);
          else               idle($urandom_range(7));
        end
      end
      if ($urandom_range(39) == 0) begin
        strobe(8'hDA);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
      idle($urandom_range(3));
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
- Sits directly upstream of ad5302_module.
- Collects a stream of bytes from the UART receiver, assembling 4 bytes (MSB first) into one 32-bit command word.
- Validates the command header and channel fields, then presents the word on uart_reg with a one-cycle uart_ready pulse.
- Drops partial frames after an inter-byte timeout so the byte stream resynchronises.
- Command format: [31:20] header (0xDAC), [19:16] channel, [15:0] data.

Parameters:
- TIMEOUT_CYCLES, 100000, idle clocks allowed between bytes of one frame before the partial frame is discarded (1 ms at 100 MHz).
- HDR_EN, 1, 1 = enforce header/channel check; 0 = pass every complete frame.
- HDR_VAL, 12'hDAC, required value of bits [31:20].
- CH_MAX, 1, highest legal channel number in bits [19:16].

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- rx_data  input  8  received byte from UART RX
- rx_valid  input  1  one-cycle strobe, rx_data valid
- uart_reg  output  32  last accepted command word
- uart_ready  output  1  one-cycle pulse, uart_reg newly updated
- frame_err  output  1  one-cycle pulse, frame rejected (header/channel) or timed out
- byte_cnt  output  2  bytes held of current frame (debug)

Behaviour:
- Reset (async, rst=1): uart_reg=0, uart_ready=0, frame_err=0, byte_cnt=0, shift register=0, timeout counter=0, state=IDLE. All outputs are registered.
- States: IDLE (no bytes held), COLLECT (1-3 bytes held).
- IDLE + rx_valid: shift[31:24]<=rx_data, byte_cnt<=1, go COLLECT, timeout counter cleared.
- COLLECT + rx_valid, byte_cnt<3: shift in the next byte at the next lower byte lane, byte_cnt++, timeout counter cleared.
- COLLECT + rx_valid, byte_cnt==3: the frame is complete in cycle N; return to IDLE and set byte_cnt<=0. In cycle N+1 exactly one of the following holds:
  - Frame valid (HDR_EN=0, or [31:20]==HDR_VAL and [19:16]<=CH_MAX): uart_reg<=full word and uart_ready=1 for exactly one cycle.
  - Frame invalid: frame_err=1 for one cycle, and uart_reg is unchanged.
- Latency: last byte strobe to uart_ready = 1 clock.
- uart_reg holds its value until the next valid frame; it is never cleared except by reset.
- COLLECT with no rx_valid: the timeout counter increments. When it reaches TIMEOUT_CYCLES-1:
  - discard the partial frame, byte_cnt<=0, go IDLE;
  - frame_err pulses 1 cycle;
  - uart_ready stays 0.
- Simultaneous rx_valid and timeout terminal count: the byte wins. It is accepted and the counter clears; no error.
- The counter saturates and never wraps. It is held at 0 in IDLE.
- rx_valid on consecutive cycles: every strobe is accepted; no back-pressure exists. A new frame may start in the same cycle uart_ready is high.
- Reset mid-frame: partial frame discarded, no pulse on uart_ready or frame_err.
- Width rule: the counter width is clog2(TIMEOUT_CYCLES)+1.

Decomposition:
- Shared package ad5302_pkg holds:
  - HDR_VAL default 12'hDAC;
  - field bit positions (HDR_MSB=31, HDR_LSB=20, CH_MSB=19, CH_LSB=16, DATA_MSB=15);
  - CH_MAX default.
- ad5302_module uses the same constants.
- One natural sub-module: byte_gap_timer (counter with clear, enable, saturating terminal-count flag). Reusable for other UART command paths.
- The rest stays flat.

Test Plan:
- Bytes DA,C0,12,34 strobed 2000 clocks apart (below timeout) -> uart_reg=32'hDAC01234, uart_ready one cycle after the 4th strobe, frame_err stays 0.
- Bytes DA,C1,12,35 back-to-back on 4 consecutive cycles -> uart_reg=32'hDAC11235, single uart_ready pulse.
- Bytes AB,C0,12,34 with HDR_EN=1 -> frame_err one cycle, uart_reg keeps its previous value. The same bytes with HDR_EN=0 -> uart_reg=32'hABC01234.
- Bytes DA,C2,00,01 (channel 2 > CH_MAX) -> frame_err pulse, no uart_ready.
- Bytes DA,C0, then idle TIMEOUT_CYCLES (set to 50) -> frame_err pulse, byte_cnt=0. Then DA,C0,00,FF -> uart_reg=32'hDAC000FF.
- rst asserted after 2 bytes, released, then DA,C1,AA,55 -> no stray pulses; uart_reg=32'hDAC1AA55. Byte arriving exactly at timeout terminal count -> accepted, no frame_err.
